// File: rtl/mul_arb_pkg.sv
// Shared types for the round-robin multiplier arbiter.
// Operand/product widths and the unsigned multiply helper.
package mul_arb_pkg;

  localparam int OPER_W = 12;
  localparam int PROD_W = 24;

  typedef logic [OPER_W-1:0] oper_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Full-width unsigned product, no truncation.
  function automatic prod_t mul_u(
    input oper_t a,
    input oper_t b
  );
    return prod_t'(a) * prod_t'(b);
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Pipelined 12x12 unsigned multiplier.
// Carries valid and requester id alongside the product.
module mul_pipe
  import mul_arb_pkg::*;
#(
  parameter int LAT  = 2,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  input  logic [ID_W-1:0] in_id_i,
  input  oper_t           in_a_i,
  input  oper_t           in_b_i,
  output logic            out_valid_o,
  output logic [ID_W-1:0] out_id_o,
  output prod_t           out_prod_o,
  output logic            busy_o
);

  logic [LAT-1:0]  vld_q;
  logic [ID_W-1:0] id_q   [LAT];
  prod_t           prod_q [LAT];

  logic [LAT-1:0]  vld_d;
  logic [ID_W-1:0] id_d   [LAT];
  prod_t           prod_d [LAT];

  // Next state: valids always shift; payload only moves with a valid,
  // so the last stage keeps the previous result while idle.
  always_comb begin
    vld_d     = vld_q;
    id_d      = id_q;
    prod_d    = prod_q;
    vld_d[0]  = in_valid_i;
    if (in_valid_i) begin
      id_d[0]   = in_id_i;
      prod_d[0] = mul_u(in_a_i, in_b_i);
    end
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        id_d[k]   = id_q[k-1];
        prod_d[k] = prod_q[k-1];
      end
    end
  end

  // Stage registers; reset drops every in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        id_q[k]   <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      prod_q <= prod_d;
    end
  end

  assign out_valid_o = vld_q[LAT-1];
  assign out_id_o    = id_q[LAT-1];
  assign out_prod_o  = prod_q[LAT-1];
  assign busy_o      = |vld_q;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier.
// One grant per cycle; results tagged with requester id.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*OPER_W-1:0]  req_a,
  input  logic [N_REQ*OPER_W-1:0]  req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output prod_t                    res_prod,
  output logic                     busy
);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic [N_REQ-1:0] one_hot;
  oper_t           sel_a;
  oper_t           sel_b;

  // Search from rr_ptr upward with wrap; walking offsets from the
  // far end down lets the nearest valid requester win.
  always_comb begin
    int j;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      j = int'(rr_ptr_q) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  assign xfer    = gnt_any && !rst;
  assign one_hot = N_REQ'(1) << gnt_idx;

  assign req_ready = xfer ? one_hot : '0;
  assign sel_a     = req_a[OPER_W*gnt_idx +: OPER_W];
  assign sel_b     = req_b[OPER_W*gnt_idx +: OPER_W];

  // Pointer moves past the winner; holds when nothing transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      if (int'(gnt_idx) == N_REQ - 1) rr_ptr_d = '0;
      else                            rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  mul_pipe #(
    .LAT  (LAT),
    .ID_W (ID_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (xfer),
    .in_id_i     (gnt_idx),
    .in_a_i      (sel_a),
    .in_b_i      (sel_b),
    .out_valid_o (res_valid),
    .out_id_o    (res_id),
    .out_prod_o  (res_prod),
    .busy_o      (busy)
  );

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomized bench for mul_rr_arbiter.
// Reference model: queue of expected results plus a spec-level grant rule.
module tb_mul_rr_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int W   = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic [1:0]      res_id;
  logic [23:0]     res_prod;
  logic            busy;

  mul_rr_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_prod  (res_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [23:0] prod;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          ptr    = 0;
  int          last_id   = 0;
  logic [23:0] last_prod = '0;
  bit          pend [N];
  logic [W-1:0] a_r [N];
  logic [W-1:0] b_r [N];
  int          wait_c [N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 12'hFFF;
    if (r == 1) return 12'h000;
    return W'($urandom);
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input bit do_rst, input int dens);
    int          g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_prod", 32'(res_prod), 32'(q[0].prod));
      last_id   = q[0].id;
      last_prod = q[0].prod;
      void'(q.pop_front());
    end else begin
      chk("res_valid_idle", 32'(res_valid), 32'd0);
      chk("res_id_hold", 32'(res_id), 32'(last_id));
      chk("res_prod_hold", 32'(res_prod), 32'(last_prod));
    end
    rst = do_rst;
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        a_r[i] = pick();
        b_r[i] = pick();
        if (int'($urandom_range(0, 99)) < dens) pend[i] = 1'b1;
      end
      req_valid[i]       = pend[i];
      req_a[W*i +: W]    = a_r[i];
      req_b[W*i +: W]    = b_r[i];
    end
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (!do_rst && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!do_rst && g >= 0) begin
      q.push_back('{due: cyc + LAT, id: g,
                    prod: 24'(a_r[g]) * 24'(b_r[g])});
      pend[g] = 1'b0;
      ptr     = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i] && !do_rst) begin
        wait_c[i]++;
        chk("fairness", 32'(wait_c[i] <= N - 1), 32'd1);
      end else begin
        wait_c[i] = 0;
      end
    end
    if (do_rst) begin
      q.delete();
      ptr       = 0;
      last_id   = 0;
      last_prod = '0;
    end
    cyc++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      wait_c[i] = 0;
    end
    @(posedge clk);
    // Reset held with a request pending: no grant allowed.
    pend[2] = 1'b1;
    cycle(1'b1, 0);
    pend[2] = 1'b0;
    cycle(1'b1, 0);
    // Single max-operand op from requester 0.
    pend[0] = 1'b1;
    a_r[0]  = 12'hFFF;
    b_r[0]  = 12'hFFF;
    cycle(1'b0, 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 0);
    // All requesters saturated.
    for (int k = 0; k < 12; k++) cycle(1'b0, 100);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0);
    // Heavy traffic then reset mid-flight.
    for (int k = 0; k < 5; k++) cycle(1'b0, 80);
    cycle(1'b1, 80);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0);
    // Long randomized run with occasional resets and idle gaps.
    for (int k = 0; k < 3000; k++) begin
      int d;
      d = (k / 200) % 3 == 0 ? 90 : ((k / 200) % 3 == 1 ? 25 : 5);
      cycle($urandom_range(0, 99) == 0, d);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
